// File: rtl/resistor_string_trim_ctrl.sv
//------------------------------------------------------------------------------
// Module  : resistor_string_trim_ctrl
// Brief   : Steps a unit-resistor string one unit at a time with settle dwell;
//           provides a per-unit DFT continuity scan.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module resistor_string_trim_ctrl #(
  parameter int NUNITS = 3,
  parameter int SETTLE = 4,
  parameter int CODEW  = $clog2(NUNITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODEW-1:0]  code,
  input  logic              load,
  input  logic              dft_en,
  input  logic              iso_en,
  output logic [NUNITS-1:0] byp,
  output logic              iso,
  output logic [CODEW-1:0]  active,
  output logic              busy,
  output logic              done,
  output logic [CODEW-1:0]  dft_idx,
  output logic              dft_act
);

  localparam logic [CODEW-1:0] C_NMAX   = CODEW'(NUNITS);
  localparam logic [CODEW-1:0] C_ONE    = CODEW'(1);
  localparam logic [CODEW-1:0] C_LAST   = CODEW'(NUNITS - 1);
  localparam logic [CODEW:0]   C_NMAX_X = (CODEW+1)'(NUNITS);
  localparam logic [7:0]       C_SETTLE = 8'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_STEP        = 3'd1,
    S_DWELL       = 3'd2,
    S_DFT_SCAN    = 3'd3,
    S_DFT_DWELL   = 3'd4,
    S_DFT_RESTORE = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [CODEW-1:0]   r_active, w_active;
  logic [CODEW-1:0]   r_tgt, w_tgt;
  logic [7:0]         r_cnt, w_cnt;
  logic [NUNITS-1:0]  r_byp, w_byp;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [CODEW-1:0]   r_idx, w_idx;
  logic               r_act, w_act;
  logic               r_dft_used, w_dft_used;
  logic               r_iso;
  logic               w_restore;
  logic [CODEW-1:0]   w_clamp;
  logic [CODEW:0]     w_code_x;

  // Units 0..a-1 stay in series; the rest are shorted.
  function automatic logic [NUNITS-1:0] f_normal(input logic [CODEW-1:0] a);
    logic [NUNITS-1:0] m;
    for (int i = 0; i < NUNITS; i++) m[i] = (i >= int'(a));
    return m;
  endfunction

  function automatic logic [NUNITS-1:0] f_scan(input logic [CODEW-1:0] k);
    logic [NUNITS-1:0] m;
    for (int i = 0; i < NUNITS; i++) m[i] = (i != int'(k));
    return m;
  endfunction

  assign w_code_x = {1'b0, code};
  assign w_clamp  = (code == '0)          ? C_ONE  :
                    (w_code_x > C_NMAX_X) ? C_NMAX : code;

  always_comb begin
    w_state    = r_state;
    w_active   = r_active;
    w_tgt      = r_tgt;
    w_cnt      = r_cnt;
    w_byp      = r_byp;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_idx      = r_idx;
    w_act      = r_act;
    w_restore  = 1'b0;
    // A scan is consumed until dft_en has been seen low again.
    w_dft_used = r_dft_used & dft_en;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          if (w_clamp == r_active) begin
            w_done = 1'b1;
          end else begin
            w_tgt   = w_clamp;
            w_busy  = 1'b1;
            w_state = S_STEP;
          end
        end else if (dft_en && !r_dft_used) begin
          w_dft_used = 1'b1;
          w_state    = S_DFT_SCAN;
          w_byp      = f_scan('0);
          w_idx      = '0;
          w_act      = 1'b1;
          w_busy     = 1'b1;
          w_cnt      = C_SETTLE;
        end
      end
      S_STEP: begin
        if (load) w_tgt = w_clamp;
        if (r_active == r_tgt) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_active = (r_active < r_tgt) ? r_active + C_ONE : r_active - C_ONE;
          w_byp    = f_normal(w_active);
          w_cnt    = C_SETTLE;
          w_state  = S_DWELL;
        end
      end
      S_DWELL: begin
        if (load) w_tgt = w_clamp;
        if (r_cnt <= 8'd1) w_state = S_STEP;
        else               w_cnt   = r_cnt - 8'd1;
      end
      S_DFT_SCAN, S_DFT_DWELL: begin
        if (!dft_en) begin
          w_restore = 1'b1;
        end else if (r_cnt <= 8'd1) begin
          if (r_idx == C_LAST) begin
            w_restore = 1'b1;
          end else begin
            w_idx   = r_idx + C_ONE;
            w_byp   = f_scan(w_idx);
            w_cnt   = C_SETTLE;
            w_state = S_DFT_SCAN;
          end
        end else begin
          w_cnt   = r_cnt - 8'd1;
          w_state = S_DFT_DWELL;
        end
      end
      S_DFT_RESTORE: w_state = S_IDLE;
      default:       w_state = S_IDLE;
    endcase
    if (w_restore) begin
      w_state = S_DFT_RESTORE;
      w_byp   = f_normal(r_active);
      w_act   = 1'b0;
      w_idx   = '0;
      w_done  = 1'b1;
      w_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_active   <= C_NMAX;
      r_tgt      <= C_NMAX;
      r_cnt      <= '0;
      r_byp      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_act      <= 1'b0;
      r_dft_used <= 1'b0;
      r_iso      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_active   <= w_active;
      r_tgt      <= w_tgt;
      r_cnt      <= w_cnt;
      r_byp      <= w_byp;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_idx      <= w_idx;
      r_act      <= w_act;
      r_dft_used <= w_dft_used;
      r_iso      <= iso_en;
    end
  end

  assign byp     = r_byp;
  assign iso     = r_iso;
  assign active  = r_active;
  assign busy    = r_busy;
  assign done    = r_done;
  assign dft_idx = r_idx;
  assign dft_act = r_act;

endmodule

`default_nettype wire

// File: tb/tb_resistor_string_trim_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_resistor_string_trim_ctrl
// Brief   : Directed + randomized bench with a schedule-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_resistor_string_trim_ctrl;

  localparam int N  = 3;
  localparam int S  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] code = '0;
  logic          load = 1'b0;
  logic          dft_en = 1'b0;
  logic          iso_en = 1'b0;
  logic [N-1:0]  byp;
  logic          iso;
  logic [CW-1:0] active;
  logic          busy;
  logic          done;
  logic [CW-1:0] dft_idx;
  logic          dft_act;

  int vectors = 0;
  int miscompares = 0;
  int m_active;

  always #5 clk = ~clk;

  resistor_string_trim_ctrl #(.NUNITS(N), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .code(code), .load(load), .dft_en(dft_en),
    .iso_en(iso_en), .byp(byp), .iso(iso), .active(active), .busy(busy),
    .done(done), .dft_idx(dft_idx), .dft_act(dft_act)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampc(input int c);
    int v;
    v = c & ((1 << CW) - 1);
    if (v == 0) return 1;
    if (v > N) return N;
    return v;
  endfunction

  function automatic int map_byp(input int a);
    return ((1 << N) - 1) ^ ((1 << a) - 1);
  endfunction

  function automatic int scan_byp(input int k);
    return ((1 << N) - 1) ^ (1 << k);
  endfunction

  // Advance one clock; ISO must equal the iso_en present at that edge.
  task automatic tick();
    logic p;
    p = iso_en;
    @(posedge clk);
    @(negedge clk);
    chk("iso", 32'(iso), rst ? 32'd0 : 32'(p));
    iso_en = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_norm(input int n, input int a, input int bs, input int dn);
    chk($sformatf("active@%0d", n), 32'(active), a);
    chk($sformatf("byp@%0d", n), 32'(byp), map_byp(a));
    chk($sformatf("busy@%0d", n), 32'(busy), bs);
    chk($sformatf("done@%0d", n), 32'(done), dn);
  endtask

  // Step opportunities fall at n = 1 + j*(S+1); each uses the latest target
  // latched strictly before it and either moves one unit or finishes.
  task automatic run_step(input int c, input int rl_n, input int rl_c, input bit post);
    int a, tgt;
    bit run;
    a   = m_active;
    tgt = clampc(c);
    run = 1'b1;
    code = CW'(c);
    load = 1'b1;
    for (int n = 0; n < 1000 && run; n++) begin
      tick();
      if (n == 0) begin
        if (a == tgt) run = 1'b0;
      end else if ((n - 1) % (S + 1) == 0) begin
        if (a == tgt) run = 1'b0;
        else a += (tgt > a) ? 1 : -1;
      end
      if (n == rl_n) tgt = clampc(rl_c);
      chk_norm(n, a, run ? 1 : 0, run ? 0 : 1);
      load = (n + 1 == rl_n);
      if (load) code = CW'(rl_c);
    end
    load = 1'b0;
    m_active = a;
    if (post) begin
      tick();
      chk_norm(-1, a, 0, 0);
    end
  endtask

  task automatic run_scan(input int ab_n, input bit ldg);
    int a, rest_n, k;
    a = m_active;
    rest_n = (ab_n >= 0) ? ab_n + 1 : N * S;
    dft_en = 1'b1;
    for (int n = 0; n <= rest_n; n++) begin
      tick();
      if (n < rest_n) begin
        k = n / S;
        chk($sformatf("scan_byp@%0d", n), 32'(byp), scan_byp(k));
        chk($sformatf("scan_idx@%0d", n), 32'(dft_idx), k);
        chk($sformatf("scan_act@%0d", n), 32'(dft_act), 1);
        chk($sformatf("scan_busy@%0d", n), 32'(busy), 1);
        chk($sformatf("scan_done@%0d", n), 32'(done), 0);
        chk($sformatf("scan_active@%0d", n), 32'(active), a);
      end else begin
        chk_norm(n, a, 0, 1);
        chk("restore_act", 32'(dft_act), 0);
      end
      load = ldg && (n == 1);
      code = CW'(1);
      if (n == ab_n) dft_en = 1'b0;
    end
    load = 1'b0;
    tick();
    chk_norm(-2, a, 0, 0);
    tick();
    chk("no_rescan_act", 32'(dft_act), 0);
    chk_norm(-3, a, 0, 0);
    dft_en = 1'b0;
    tick();
  endtask

  initial begin
    int c, rl, ab;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_active", 32'(active), N);
    chk("rst_byp", 32'(byp), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(dft_idx), 0);
    chk("rst_act", 32'(dft_act), 0);
    chk("rst_iso", 32'(iso), 0);
    m_active = N;
    tick();
    chk_norm(-4, N, 0, 0);

    run_step(1, -1, 0, 1);      // 3 -> 1, two steps
    run_step(0, -1, 0, 1);      // clamps to 1: immediate DONE
    run_step(7, -1, 0, 1);      // over-range -> 3
    run_step(1, 2, 3, 1);       // reverse during first dwell: 3,2,3
    run_step(2, -1, 0, 1);
    run_scan(-1, 1'b1);         // full scan, LOAD ignored mid-scan
    run_scan(S + 1, 1'b0);      // abort while idx=1

    for (int it = 0; it < 10; it++) begin
      c  = int'($urandom_range(0, (1 << CW) - 1));
      rl = -1;
      if (clampc(c) != m_active && $urandom_range(0, 1) == 1)
        rl = int'($urandom_range(2, S + 1));
      run_step(c, rl, int'($urandom_range(0, (1 << CW) - 1)), 1'b1);
    end
    for (int it = 0; it < 3; it++) begin
      ab = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, N * S - 1));
      run_scan(ab, 1'($urandom_range(0, 1)));
    end

    // LOAD and DFT_EN together: stepping first, scan right after DONE.
    run_step(2, -1, 0, 1'b1);
    dft_en = 1'b1;
    run_step(3, -1, 0, 1'b0);
    tick();
    chk("ld_dft_act", 32'(dft_act), 1);
    chk("ld_dft_byp", 32'(byp), scan_byp(0));
    chk("ld_dft_idx", 32'(dft_idx), 0);
    chk("ld_dft_busy", 32'(busy), 1);
    dft_en = 1'b0;
    tick();
    chk_norm(-5, 3, 0, 1);
    tick();
    chk_norm(-6, 3, 0, 0);

    // Asynchronous reset in the middle of a step sequence.
    code = CW'(1);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("pre_rst_active", 32'(active), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_active", 32'(active), N);
    chk("arst_byp", 32'(byp), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_act", 32'(dft_act), 0);
    @(negedge clk);
    rst = 1'b0;
    m_active = N;
    tick();
    chk_norm(-7, N, 0, 0);
    tick();
    chk_norm(-8, N, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/resistor_string_trim_ctrl.md
Name: resistor_string_trim_ctrl

Overview:
- Sequential controller for a generated poly resistor string of NUNITS series unit resistors; each unit has a bypass switch.
- Moves the string from its current active-unit count to a requested count one unit at a time, with a programmable settle dwell between steps, so the analog node never sees a multi-unit jump.
- Provides a DFT continuity scan that isolates each unit in turn.
- Sits between the trim register bank and the resistor brick's bypass/ISO pins.

Parameters:
- NUNITS, 3, number of series unit resistors (legal 1..16).
- SETTLE, 4, dwell cycles after every switch change (legal 1..255).
- CODEW, $clog2(NUNITS+1), width of count fields.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- CODE  in  CODEW  requested active unit count; sampled with LOAD.
- LOAD  in  1  one-cycle request strobe.
- DFT_EN  in  1  level; requests and holds a continuity scan.
- ISO_EN  in  1  isolation enable, registered to ISO.
- BYP  out  NUNITS  bypass enables, 1 = unit shorted.
- ISO  out  1  registered ISO_EN, drives every unit ISO pin.
- ACTIVE  out  CODEW  current active unit count.
- BUSY  out  1  high while stepping or scanning.
- DONE  out  1  one-cycle completion pulse.
- DFT_IDX  out  CODEW  unit under test during scan.
- DFT_ACT  out  1  high while in scan.

Behaviour:
- Reset (async assert, sync release) state:
  - ACTIVE=NUNITS, which is maximum resistance and the safe state.
  - BYP=0, ISO=0, BUSY=0, DONE=0, DFT_IDX=0, DFT_ACT=0.
  - FSM=IDLE.
- Normal mode mapping: BYP[i] = (i >= ACTIVE), i.e. units 0..ACTIVE-1 are in series. BYP and ACTIVE are registered and change on the same edge.
- Target clamp: CODE=0 -> 1 (at least one unit always in series). CODE>NUNITS -> NUNITS.
- FSM states: IDLE, STEP, DWELL, DFT_SCAN, DFT_DWELL, DFT_RESTORE.
- IDLE:
  - LOAD with clamped target == ACTIVE: DONE pulses on the next edge; BUSY stays 0; BYP unchanged.
  - LOAD with target != ACTIVE: latch target, go to STEP; BUSY=1 from the next edge.
  - Rising-level DFT_EN with no LOAD: go to DFT_SCAN.
  - LOAD and DFT_EN in the same cycle: LOAD wins; the scan starts after DONE if DFT_EN is still high.
- STEP (one cycle): ACTIVE moves +/-1 toward target, then go to DWELL with counter=SETTLE.
- DWELL: decrement counter each cycle. At 0:
  - ACTIVE != target: go to STEP.
  - ACTIVE == target: go to IDLE; DONE=1 for one cycle on that edge; BUSY falls on the same edge.
- Timing for LOAD sampled at edge t, distance d: first ACTIVE change at t+1; k-th change at t+1+(k-1)(SETTLE+1); DONE at t+1+d(SETTLE+1).
- LOAD while BUSY (stepping): relatch the clamped target.
  - The current dwell always completes before the next step.
  - Direction may reverse.
  - Relatch to the current ACTIVE ends the sequence at the end of the dwell.
- LOAD during a scan is ignored.
- DFT_SCAN: for k = 0..NUNITS-1:
  - BYP = all ones except bit k; DFT_IDX=k; DFT_ACT=1; BUSY=1.
  - Hold SETTLE cycles in DFT_DWELL, then advance k.
  - After the last unit, go to DFT_RESTORE.
- DFT_RESTORE: BYP returns to the normal mapping of the unchanged ACTIVE; DFT_ACT=0; DONE pulse; go to IDLE.
- A new scan requires DFT_EN low then high again.
- DFT_EN falling mid-scan: the next edge goes to DFT_RESTORE (abort); DONE still pulses.
- ISO = ISO_EN delayed one cycle, independent of the FSM.
- Reset asserted mid-operation: all outputs go immediately to reset values; any latched target or scan is discarded.
- ACTIVE never leaves 1..NUNITS; BYP is never all ones outside a scan with NUNITS>1.

Test Plan:
- Reset release, NUNITS=3, SETTLE=4 -> ACTIVE=3, BYP=3'b000, BUSY=0, ISO=0.
- LOAD CODE=1 at edge t:
  - ACTIVE=2/BYP=3'b100 at t+1.
  - ACTIVE=1/BYP=3'b110 at t+6.
  - DONE pulse and BUSY low at t+11.
- LOAD CODE=0 from ACTIVE=1 -> clamps to 1; DONE at the next edge, BUSY never asserts. LOAD CODE=7 -> target 3.
- From ACTIVE=3, LOAD CODE=1, then LOAD CODE=3 during the first dwell -> ACTIVE sequence 3,2,3; DONE at t+11.
- DFT_EN rise from ACTIVE=2 -> BYP 3'b110, 3'b101, 3'b011 for 4 cycles each with DFT_IDX 0,1,2; then BYP=3'b100 with a DONE pulse.
- DFT_EN drop during DFT_IDX=1 -> BYP restores to 3'b100 on the next edge, DONE pulses. RST asserted mid-step -> ACTIVE=3, BYP=0 asynchronously.
